// File: rtl/bram_read_initiator_if.sv
// Client-side request/response, write and RAM-port signals of bram_read_initiator.
// slave: the initiator itself; master: client logic together with the RAM.
interface bram_read_initiator_if #(
    parameter int unsigned dataSize = 32,
    parameter int unsigned addrSize = 9
);
    logic                reqEnable;
    logic [addrSize-1:0] reqAddr;
    logic                reqReady;

    logic                respValid;
    logic [dataSize-1:0] respData;
    logic                respDeq;

    logic                wrEnable;
    logic [addrSize-1:0] wrAddr;
    logic [dataSize-1:0] wrData;
    logic                wrReady;

    logic                bramReadEnable;
    logic [addrSize-1:0] bramReadAddr;
    logic [dataSize-1:0] bramReadData;
    logic                bramWriteEnable;
    logic [addrSize-1:0] bramWriteAddr;
    logic [dataSize-1:0] bramWriteData;

    logic                noPending;

    modport slave (
        input  reqEnable, reqAddr, respDeq, wrEnable, wrAddr, wrData, bramReadData,
        output reqReady, respValid, respData, wrReady, noPending,
               bramReadEnable, bramReadAddr,
               bramWriteEnable, bramWriteAddr, bramWriteData
    );

    modport master (
        output reqEnable, reqAddr, respDeq, wrEnable, wrAddr, wrData, bramReadData,
        input  reqReady, respValid, respData, wrReady, noPending,
               bramReadEnable, bramReadAddr,
               bramWriteEnable, bramWriteAddr, bramWriteData
    );
endinterface

// File: rtl/bram_read_initiator.sv
// Credit-flow-controlled read front end for a one-cycle-latency block RAM with a response FIFO.
// Define BRAM_READ_INITIATOR_RAW_FWD_EN to forward same-cycle write data into a colliding read.
module bram_read_initiator #(
    parameter int unsigned dataSize  = 32,
    parameter int unsigned addrSize  = 9,
    parameter int unsigned respDepth = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    bram_read_initiator_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(respDepth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [dataSize-1:0] mem_q [respDepth];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                in_flight_q, in_flight_d;
    logic                resp_valid_q, resp_valid_d;
    logic [dataSize-1:0] resp_data_q, resp_data_d;
    logic                no_pending_q, no_pending_d;

    logic [CNT_W-1:0]    credits;
    logic                req_ready;
    logic                accept;
    logic                push;
    logic                pop;
    logic [dataSize-1:0] push_data;

    // Every accepted read owns a FIFO slot from issue until it is popped.
    assign credits   = count_q + CNT_W'(in_flight_q);
    assign req_ready = RST_N & (credits < CNT_W'(respDepth));
    assign accept    = bus.reqEnable & req_ready;
    assign push      = in_flight_q;
    assign pop       = bus.respDeq & resp_valid_q;

`ifdef BRAM_READ_INITIATOR_RAW_FWD_EN
    logic                fwd_q, fwd_d;
    logic [dataSize-1:0] fwd_data_q, fwd_data_d;

    // A read colliding with a same-cycle write returns the new data.
    always_comb begin
        fwd_d      = accept & bus.wrEnable & (bus.wrAddr == bus.reqAddr);
        fwd_data_d = fwd_data_q;
        if (fwd_d) begin
            fwd_data_d = bus.wrData;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign push_data = fwd_q ? fwd_data_q : bus.bramReadData;
`else
    assign push_data = bus.bramReadData;
`endif

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        in_flight_d  = accept;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        no_pending_d = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head register: a push into an empty (or emptying) FIFO becomes the head directly.
        resp_valid_d = (count_d != '0);
        if (resp_valid_d) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                resp_data_d = push_data;
            end else begin
                resp_data_d = mem_q[rd_ptr_d];
            end
        end
        no_pending_d = (count_d == '0) & ~in_flight_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_flight_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            no_pending_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_flight_q  <= in_flight_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            no_pending_q <= no_pending_d;
        end
    end

    // FIFO storage needs no reset; occupancy gates what is visible.
    always_ff @(posedge CLK) begin
        if (RST_N && push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign bus.reqReady        = req_ready;
    assign bus.respValid       = resp_valid_q;
    assign bus.respData        = resp_data_q;
    assign bus.noPending       = no_pending_q;
    assign bus.wrReady         = 1'b1;
    assign bus.bramReadEnable  = accept;
    assign bus.bramReadAddr    = bus.reqAddr;
    assign bus.bramWriteEnable = bus.wrEnable;
    assign bus.bramWriteAddr   = bus.wrAddr;
    assign bus.bramWriteData   = bus.wrData;

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
        !(push && !pop && (count_q == CNT_W'(respDepth))));

    a_credit_bound: assert property (@(posedge CLK) disable iff (!RST_N)
        credits <= CNT_W'(respDepth));

endmodule

// File: tb/tb_bram_read_initiator.sv
// Randomized scoreboard bench for bram_read_initiator with a behavioural RAM and reference memory.
module tb_bram_read_initiator;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 2;
`ifdef BRAM_READ_INITIATOR_RAW_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    bram_read_initiator_if #(.dataSize(DW), .addrSize(AW)) bus ();

    bram_read_initiator #(.dataSize(DW), .addrSize(AW), .respDepth(DEPTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    exp_t          sb[$];
    logic [DW-1:0] ram     [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];

    int            n_checks = 0;
    int            n_pass   = 0;
    bit            running  = 1'b0;
    bit            rst_prev = 1'b0;
    bit            last_acc = 1'b0;
    int            re_count = 0;
    bit            want_valid;

    logic          pend_re = 1'b0;
    logic          pend_we = 1'b0;
    logic [AW-1:0] pend_raddr = '0;
    logic [AW-1:0] pend_waddr = '0;
    logic [DW-1:0] pend_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
        end
    endtask

    // Response monitor: head must be visible two cycles after its read was accepted.
    always @(negedge CLK) begin
        if (running && RST_N) begin
            want_valid = (sb.size() != 0) && (sb[0].cyc <= cyc - 2);
            check("resp_valid", 64'(bus.respValid), 64'(want_valid));
            if (want_valid && bus.respValid) begin
                check("resp_data", 64'(bus.respData), 64'(sb[0].data));
                if (bus.respDeq) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cycle(input bit rst_n, input bit ren, input logic [AW-1:0] raddr,
                         input bit wen, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                         input bit deq);
        bit   want_ready;
        exp_t e;
        @(posedge CLK);
        #1;
        // RAM: registered read of last cycle's address, read-before-write.
        if (pend_re) bus.bramReadData = ram[pend_raddr];
        if (pend_we) ram[pend_waddr] = pend_wdata;
        if (rst_prev) sb.delete();
        if (running) check("no_pending", 64'(bus.noPending), 64'(sb.size() == 0));

        RST_N         = rst_n;
        bus.reqEnable = ren;
        bus.reqAddr   = raddr;
        bus.wrEnable  = wen;
        bus.wrAddr    = waddr;
        bus.wrData    = wdata;
        bus.respDeq   = deq;
        #1;

        want_ready = rst_n && (sb.size() < int'(DEPTH));
        last_acc   = ren && want_ready;
        if (running) begin
            check("req_ready", 64'(bus.reqReady), 64'(want_ready));
            check("wr_ready", 64'(bus.wrReady), 64'(1));
            check("bram_re", 64'(bus.bramReadEnable), 64'(last_acc));
            if (last_acc) check("bram_raddr", 64'(bus.bramReadAddr), 64'(raddr));
            check("bram_we", 64'(bus.bramWriteEnable), 64'(wen));
            if (wen) begin
                check("bram_waddr", 64'(bus.bramWriteAddr), 64'(waddr));
                check("bram_wdata", 64'(bus.bramWriteData), 64'(wdata));
            end
        end

        pend_re    = bus.bramReadEnable;
        pend_raddr = bus.bramReadAddr;
        pend_we    = bus.bramWriteEnable;
        pend_waddr = bus.bramWriteAddr;
        pend_wdata = bus.bramWriteData;
        re_count  += int'(bus.bramReadEnable);

        if (last_acc) begin
            e.data = (FWD && wen && (waddr == raddr)) ? wdata : ref_mem[raddr];
            e.cyc  = cyc;
            sb.push_back(e);
        end
        if (wen) ref_mem[waddr] = wdata;
        rst_prev = !rst_n;
    endtask

    task automatic idle(input int n, input bit deq);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, deq);
    endtask

    initial begin
        logic [DW-1:0] v;
        int            a;
        bit            r_rst, r_ren, r_wen, r_deq;
        logic [AW-1:0] r_raddr, r_waddr;

        bus.reqEnable    = 1'b0;
        bus.reqAddr      = '0;
        bus.respDeq      = 1'b0;
        bus.wrEnable     = 1'b0;
        bus.wrAddr       = '0;
        bus.wrData       = '0;
        bus.bramReadData = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            v          = $urandom;
            ram[i]     = v;
            ref_mem[i] = v;
        end
        ram[5]      = 32'hDEAD_BEEF;
        ref_mem[5]  = 32'hDEAD_BEEF;
        ram[16]     = 32'h0000_AAAA;
        ref_mem[16] = 32'h0000_AAAA;

        cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0, '0, '0, 1'b0);
        running = 1'b1;

        // Single read after reset, held in the FIFO before popping.
        cycle(1'b1, 1'b1, AW'(5), 1'b0, '0, '0, 1'b0);
        check("reset_resp_data", 64'(bus.respData), 64'(0));
        check("reset_resp_valid", 64'(bus.respValid), 64'(0));
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Fill credits with no dequeue, then free exactly one slot.
        re_count = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, AW'(32 + i), 1'b0, '0, '0, 1'b0);
        check("fill_accepts", 64'(re_count), 64'(DEPTH));
        re_count = 0;
        cycle(1'b1, 1'b1, AW'(40), 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, AW'(41 + i), 1'b0, '0, '0, 1'b0);
        check("refill_accepts", 64'(re_count), 64'(1));
        idle(6, 1'b1);

        // Sequential addresses 0..7 with dequeue held high; pointers wrap several times.
        a = 0;
        for (int k = 0; k < 40 && a < 8; k++) begin
            cycle(1'b1, 1'b1, AW'(a), 1'b0, '0, '0, 1'b1);
            if (last_acc) a++;
        end
        check("walk_issued", 64'(a), 64'(8));
        idle(6, 1'b1);

        // Read and write to the same address in one cycle.
        cycle(1'b1, 1'b1, AW'(16), 1'b1, AW'(16), 32'h0000_1234, 1'b1);
        idle(4, 1'b1);
        cycle(1'b1, 1'b1, AW'(16), 1'b0, '0, '0, 1'b1);
        idle(4, 1'b1);

        // Reset with one FIFO entry held and a second read in flight.
        cycle(1'b1, 1'b1, AW'(1), 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, AW'(2), 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, AW'(3), 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        check("post_reset_ready", 64'(bus.reqReady), 64'(1));
        idle(4, 1'b1);

        // Randomized traffic, addresses concentrated to provoke collisions.
        for (int k = 0; k < 600; k++) begin
            r_rst   = ($urandom_range(0, 99) != 0);
            r_ren   = ($urandom_range(0, 1) != 0);
            r_raddr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            r_wen   = ($urandom_range(0, 2) == 0);
            r_waddr = AW'($urandom_range(0, 15));
            r_deq   = ($urandom_range(0, 3) != 0);
            cycle(r_rst, r_ren, r_raddr, r_wen, r_waddr, DW'($urandom), r_deq);
        end

        idle(8, 1'b1);
        check("drain_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
